// File: rtl/wishbone_master_adapter.sv
// Wishbone classic master for RV32I loads/stores.
// One outstanding access, registered outputs, abort on timeout.
module wishbone_master_adapter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [1:0]  cpu_size_i,
  input  logic        cpu_unsigned_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    BUS
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;

  logic [31:0] rdata_d;
  logic        done_d;
  logic        err_d;
  logic        busy_d;
  logic [31:0] adr_d;
  logic [31:0] dat_d;
  logic [3:0]  sel_d;
  logic        we_d;
  logic        cyc_d;
  logic        stb_d;

  logic        bad;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [31:0] lane;
  logic [31:0] ld_val;

  // Alignment check plus byte-lane select / replicated store data.
  always_comb begin
    bad     = 1'b0;
    req_sel = 4'b0000;
    req_dat = 32'h0;
    case (cpu_size_i)
      2'b00: begin
        req_sel = 4'b0001 << cpu_addr_i[1:0];
        req_dat = {4{cpu_wdata_i[7:0]}};
      end
      2'b01: begin
        bad     = cpu_addr_i[0];
        req_sel = 4'b0011 << cpu_addr_i[1:0];
        req_dat = {2{cpu_wdata_i[15:0]}};
      end
      2'b10: begin
        bad     = |cpu_addr_i[1:0];
        req_sel = 4'b1111;
        req_dat = cpu_wdata_i;
      end
      default: bad = 1'b1;
    endcase
    if (!cpu_we_i) req_dat = 32'h0;
  end

  // Pick the addressed lane of read data and extend it.
  always_comb begin
    lane   = wb_dat_i >> {off_q, 3'b000};
    ld_val = lane;
    case (size_q)
      2'b00: ld_val = uns_q ? {24'h0, lane[7:0]}
                            : {{24{lane[7]}}, lane[7:0]};
      2'b01: ld_val = uns_q ? {16'h0, lane[15:0]}
                            : {{16{lane[15]}}, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BUS machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = 32'h0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = cpu_busy_o;
    adr_d   = wb_adr_o;
    dat_d   = wb_dat_o;
    sel_d   = wb_sel_o;
    we_d    = wb_we_o;
    cyc_d   = wb_cyc_o;
    stb_d   = wb_stb_o;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            off_d   = cpu_addr_i[1:0];
            size_d  = cpu_size_i;
            uns_d   = cpu_unsigned_i;
            cnt_d   = '0;
            adr_d   = {cpu_addr_i[31:2], 2'b00};
            dat_d   = req_dat;
            sel_d   = req_sel;
            we_d    = cpu_we_i;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (wb_ack_i || cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = !wb_ack_i;
          if (wb_ack_i && !wb_we_o) rdata_d = ld_val;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          adr_d   = 32'h0;
          dat_d   = 32'h0;
          sel_d   = 4'b0000;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      cpu_rdata_o <= 32'h0;
      cpu_done_o  <= 1'b0;
      cpu_err_o   <= 1'b0;
      cpu_busy_o  <= 1'b0;
      wb_adr_o    <= 32'h0;
      wb_dat_o    <= 32'h0;
      wb_sel_o    <= 4'b0000;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cpu_rdata_o <= rdata_d;
      cpu_done_o  <= done_d;
      cpu_err_o   <= err_d;
      cpu_busy_o  <= busy_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      wb_sel_o    <= sel_d;
      wb_we_o     <= we_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= stb_d;
    end
  end

endmodule

// File: tb/tb_wishbone_master_adapter.sv
// Directed bench for wishbone_master_adapter.
// Each task drives one scenario and checks inline.
module tb_wishbone_master_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_uns = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_busy;
  logic [31:0] wb_adr;
  logic [31:0] wb_dato;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dati = 32'h0;
  logic        wb_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  wishbone_master_adapter #(.TIMEOUT(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_req_i      (cpu_req),
    .cpu_we_i       (cpu_we),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_size_i     (cpu_size),
    .cpu_unsigned_i (cpu_uns),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_done_o     (cpu_done),
    .cpu_err_o      (cpu_err),
    .cpu_busy_o     (cpu_busy),
    .wb_adr_o       (wb_adr),
    .wb_dat_o       (wb_dato),
    .wb_sel_o       (wb_sel),
    .wb_we_o        (wb_we),
    .wb_cyc_o       (wb_cyc),
    .wb_stb_o       (wb_stb),
    .wb_dat_i       (wb_dati),
    .wb_ack_i       (wb_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz,
                       input logic u);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_size  = sz;
    cpu_uns   = u;
    step();
    cpu_req   = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] d);
    wb_ack  = 1'b1;
    wb_dati = d;
    step();
    wb_ack  = 1'b0;
    wb_dati = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_size = 2'b10;
    step();
    step();
    cpu_req = 1'b0;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus cyc=%b stb=%b busy=%b want 0",
               wb_cyc, wb_stb, cpu_busy);
    end
    checks++;
    if (cpu_done !== 1'b0 || cpu_err !== 1'b0 ||
        cpu_rdata !== 32'h0 || wb_sel !== 4'h0) begin
      errors++;
      $display("FAIL reset_out done=%b err=%b rdata=%h sel=%b want 0",
               cpu_done, cpu_err, cpu_rdata, wb_sel);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sw();
    start(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
    checks++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_cyc cyc=%b stb=%b busy=%b want 1",
               wb_cyc, wb_stb, cpu_busy);
    end
    checks++;
    if (wb_adr !== 32'h100 || wb_sel !== 4'b1111 ||
        wb_we !== 1'b1 || wb_dato !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_bus adr=%h sel=%b we=%b dat=%h want 100 1111 1 deadbeef",
               wb_adr, wb_sel, wb_we, wb_dato);
    end
    step();
    checks++;
    if (wb_cyc !== 1'b1 || cpu_done !== 1'b0 || wb_dato !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_hold cyc=%b done=%b dat=%h want 1 0 deadbeef",
               wb_cyc, cpu_done, wb_dato);
    end
    ack_with(32'h0);
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || wb_cyc !== 1'b0 ||
        cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_done done=%b err=%b cyc=%b busy=%b rdata=%h want 1 0 0 0 0",
               cpu_done, cpu_err, wb_cyc, cpu_busy, cpu_rdata);
    end
    step();
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_pulse done=%b want 0", cpu_done);
    end
  endtask

  task automatic test_byte();
    start(1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0);
    checks++;
    if (wb_sel !== 4'b1000 || wb_dato !== 32'hA5A5A5A5 ||
        wb_adr !== 32'h200) begin
      errors++;
      $display("FAIL sb_bus sel=%b dat=%h adr=%h want 1000 a5a5a5a5 200",
               wb_sel, wb_dato, wb_adr);
    end
    ack_with(32'h0);
    start(1'b0, 32'h203, 32'h0, 2'b00, 1'b0);
    checks++;
    if (wb_we !== 1'b0 || wb_dato !== 32'h0 || wb_sel !== 4'b1000) begin
      errors++;
      $display("FAIL lb_bus we=%b dat=%h sel=%b want 0 0 1000",
               wb_we, wb_dato, wb_sel);
    end
    ack_with(32'hA5000000);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'hFFFFFFA5) begin
      errors++;
      $display("FAIL lb_data done=%b rdata=%h want 1 ffffffa5",
               cpu_done, cpu_rdata);
    end
    step();
    checks++;
    if (cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL lb_clear rdata=%h want 0", cpu_rdata);
    end
    start(1'b0, 32'h203, 32'h0, 2'b00, 1'b1);
    ack_with(32'hA5000000);
    checks++;
    if (cpu_rdata !== 32'h000000A5) begin
      errors++;
      $display("FAIL lbu_data rdata=%h want 000000a5", cpu_rdata);
    end
    step();
  endtask

  task automatic test_half();
    start(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
    checks++;
    if (wb_sel !== 4'b1100 || wb_adr !== 32'h100) begin
      errors++;
      $display("FAIL lh_bus sel=%b adr=%h want 1100 100", wb_sel, wb_adr);
    end
    ack_with(32'h80011234);
    checks++;
    if (cpu_rdata !== 32'hFFFF8001 || cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL lh_data rdata=%h err=%b want ffff8001 0",
               cpu_rdata, cpu_err);
    end
    start(1'b0, 32'h102, 32'h0, 2'b01, 1'b1);
    ack_with(32'h80011234);
    checks++;
    if (cpu_rdata !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu_data rdata=%h want 00008001", cpu_rdata);
    end
    start(1'b1, 32'h006, 32'h0000BEEF, 2'b01, 1'b0);
    checks++;
    if (wb_sel !== 4'b1100 || wb_dato !== 32'hBEEFBEEF) begin
      errors++;
      $display("FAIL sh_bus sel=%b dat=%h want 1100 beefbeef",
               wb_sel, wb_dato);
    end
    ack_with(32'h0);
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h102, 32'h101, 32'h100};
    sizes = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      start(1'b0, addrs[i], 32'h0, sizes[i], 1'b0);
      checks++;
      if (wb_cyc !== 1'b0 || cpu_busy !== 1'b0 || cpu_done !== 1'b1 ||
          cpu_err !== 1'b1 || cpu_rdata !== 32'h0) begin
        errors++;
        $display("FAIL misalign%0d cyc=%b busy=%b done=%b err=%b rdata=%h want 0 0 1 1 0",
                 i, wb_cyc, cpu_busy, cpu_done, cpu_err, cpu_rdata);
      end
      step();
      checks++;
      if (cpu_done !== 1'b0 || cpu_err !== 1'b0 || wb_cyc !== 1'b0) begin
        errors++;
        $display("FAIL misalign%0d_after done=%b err=%b cyc=%b want 0",
                 i, cpu_done, cpu_err, wb_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    start(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
    n = 1;
    for (int i = 0; i < 40 && wb_cyc; i++) begin
      step();
      if (wb_cyc) n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL to_len cyc_cycles=%0d want 16", n);
    end
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b1 || cpu_busy !== 1'b0 ||
        wb_stb !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_err done=%b err=%b busy=%b stb=%b rdata=%h want 1 1 0 0 0",
               cpu_done, cpu_err, cpu_busy, wb_stb, cpu_rdata);
    end
    step();
    start(1'b0, 32'h44, 32'h0, 2'b10, 1'b0);
    ack_with(32'h12345678);
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0 ||
        cpu_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL to_next done=%b err=%b rdata=%h want 1 0 12345678",
               cpu_done, cpu_err, cpu_rdata);
    end
    step();
    start(1'b0, 32'h48, 32'h0, 2'b10, 1'b0);
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL to_c16 cyc=%b want 1", wb_cyc);
    end
    ack_with(32'hCAFEF00D);
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0 ||
        cpu_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL to_ackwins done=%b err=%b rdata=%h want 1 0 cafef00d",
               cpu_done, cpu_err, cpu_rdata);
    end
    step();
  endtask

  task automatic test_reset_in_bus();
    start(1'b1, 32'h300, 32'h11223344, 2'b10, 1'b0);
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rb_start cyc=%b want 1", wb_cyc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cpu_busy !== 1'b0 ||
        cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL rb_drop cyc=%b stb=%b busy=%b done=%b want 0",
               wb_cyc, wb_stb, cpu_busy, cpu_done);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++;
    if (cpu_done !== 1'b0 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rb_nodone done=%b cyc=%b want 0", cpu_done, wb_cyc);
    end
  endtask

  task automatic test_back_to_back();
    start(1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
    ack_with(32'h0BADF00D);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL b2b_done1 done=%b rdata=%h want 1 0badf00d",
               cpu_done, cpu_rdata);
    end
    start(1'b1, 32'h601, 32'h0000007E, 2'b00, 1'b0);
    checks++;
    if (wb_cyc !== 1'b1 || wb_adr !== 32'h600 || wb_sel !== 4'b0010 ||
        wb_dato !== 32'h7E7E7E7E || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cyc2 cyc=%b adr=%h sel=%b dat=%h done=%b want 1 600 0010 7e7e7e7e 0",
               wb_cyc, wb_adr, wb_sel, wb_dato, cpu_done);
    end
    ack_with(32'h0);
    checks++;
    if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done2 done=%b err=%b want 1 0", cpu_done, cpu_err);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_byte();
    test_half();
    test_misaligned();
    test_timeout();
    test_reset_in_bus();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_master_adapter.md
Name: wishbone_master_adapter

Overview:
- Wishbone classic master. Converts a simple single-outstanding CPU load/store request (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into one Wishbone read or write cycle.
- Sits between the RV32I core's data port and the NoC/Wishbone fabric; the far end is a Wishbone slave such as the RAM wrapper.
- Generates byte selects and lane-replicated write data, extracts and extends read data, and aborts hung cycles with a timeout.

Parameters:
TIMEOUT, 256, cycles with CYC/STB asserted and no ACK before the cycle is aborted with error (>=2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
cpu_req_i  in  1  request strobe, sampled only in IDLE
cpu_we_i  in  1  1=store, 0=load
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  store data, right-aligned
cpu_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal
cpu_unsigned_i  in  1  1=zero-extend load, 0=sign-extend
cpu_rdata_o  out  32  load result, valid while cpu_done_o=1
cpu_done_o  out  1  one-cycle completion pulse
cpu_err_o  out  1  error flag, qualified by cpu_done_o
cpu_busy_o  out  1  high while a bus cycle is in progress
wb_adr_o  out  32  word address {addr[31:2],2'b00}
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte lane select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_dat_i  in  32  read data
wb_ack_i  in  1  slave acknowledge

Behaviour:
- All outputs are registered. On the rst_i edge, every output is set to 0, the state goes to IDLE, and the timeout counter clears.
- FSM states are IDLE and BUS.
- IDLE with cpu_req_i=1 and the access aligned:
  - Latch addr, size, unsigned and we.
  - Next cycle: cyc=stb=1, busy=1, adr/sel/we/dat driven. Go to BUS.
- Misaligned or illegal access (half with addr[0]=1, word with addr[1:0]!=0, or size=11):
  - No bus cycle is issued.
  - Next cycle: done=1, err=1, rdata=0. Stay in IDLE.
- Select generation:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write data: byte is replicated {4{wdata[7:0]}}; half is replicated {2{wdata[15:0]}}; word passes through unchanged. wb_dat_o is 0 on reads.
- BUS, ack seen:
  - On wb_ack_i=1, the next cycle has cyc=stb=busy=0, done=1, err=0.
  - For reads, rdata takes the selected lane of wb_dat_i captured on the ack cycle, sign- or zero-extended to 32 bits. Writes give rdata=0. Go to IDLE.
- BUS, no ack:
  - The counter increments every cycle without ack.
  - When it reaches TIMEOUT-1 without ack, the next cycle has cyc=stb=busy=0, done=1, err=1, rdata=0. Go to IDLE.
  - If ack arrives in the same cycle the timeout is reached, ack wins and the access completes normally.
- Outputs are held stable for the entire BUS state (Wishbone classic, no pipelining, no bursts).
- Latency: request at cycle N gives cyc at N+1. With the slave acking at cycle N+k, done is at N+k+1.
- cpu_req_i is ignored in BUS. It is accepted in the IDLE cycle where done=1, so back-to-back accesses are possible.
- wb_ack_i is ignored in IDLE.
- done and err are single-cycle pulses. cpu_rdata_o returns to 0 the cycle after done.
- rst_i asserted in BUS drops cyc/stb on the next edge. No done pulse is produced and the aborted request is lost.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, slave acks 1 cycle after stb -> adr=0x100, sel=1111, we=1, dat=0xDEADBEEF; done pulse at the 3rd cycle after req; err=0.
- SB addr=0x203 wdata=0x000000A5 -> sel=1000, dat=0xA5A5A5A5, adr=0x200. Then LB addr=0x203 with wb_dat_i=0xA5000000 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr=0x102 with wb_dat_i=0x80011234 -> sel=1100, rdata=0xFFFF8001. Then LHU -> 0x00008001.
- LW addr=0x102 and LH addr=0x101 -> no cyc asserted; done=1, err=1 the next cycle.
- Slave never acks, TIMEOUT=16 -> cyc held 16 cycles, then dropped; done=1, err=1, busy=0. A subsequent LW completes normally. Ack in the 16th cycle -> err=0.
- rst_i pulsed while cyc=1 -> cyc/stb/busy=0 after the edge, no done. req raised in the done cycle of a prior access -> cyc reasserted the following cycle.
